// File: rtl/dm_pkg.sv
// dm_pkg: shared constants for the MEM-stage data memory with MMIO window.
//   - access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 behaves as word)
//   - byte offsets of the peripheral registers inside the 256-byte window
//   - bit positions inside TCON
//   - isMisaligned(): alignment rule shared by loads and stores
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [7:0] OFF_TH      = 8'h00;
  localparam logic [7:0] OFF_TL      = 8'h04;
  localparam logic [7:0] OFF_TCON    = 8'h08;
  localparam logic [7:0] OFF_LED     = 8'h0C;
  localparam logic [7:0] OFF_DIGI    = 8'h10;
  localparam logic [7:0] OFF_SYSTICK = 8'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // Size 2'b11 is handled like a word, so any size with bit1 set needs word alignment.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lowAddr);
    logic result;
    result = 1'b0;
    if (size == SZ_HALF) begin
      result = lowAddr[0];
    end else if (size[1]) begin
      result = (lowAddr != 2'b00);
    end
    return result;
  endfunction

endpackage

// File: rtl/dm_timer.sv
// dm_timer: reload timer with interrupt status, holding TH, TL and TCON.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   i_wrTh/i_wrTl/i_wrTcon  CPU write strobes for the three registers
//   i_wdata         CPU write data
//   o_th, o_tl      current reload value and count
//   o_tcon          {irq status, irq enable, timer enable}
//   o_irq           interrupt, equal to TCON irq status
module dm_timer
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wrTh,
  input  logic        i_wrTl,
  input  logic        i_wrTcon,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_irq
);

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;

  logic [31:0] w_thNext;
  logic [31:0] w_tlNext;
  logic [2:0]  w_tconNext;
  logic        w_wrap;
  logic        w_setIs;

  assign w_wrap  = r_tcon[TCON_EN] && (r_tl == 32'hFFFF_FFFF);
  assign w_setIs = w_wrap && r_tcon[TCON_IE];

  // CPU writes to TH/TL take priority over the counting update. For the status
  // bit, a CPU write can only clear it, and a hardware overflow set is applied
  // last so an interrupt arriving in the same cycle as a clear is never lost.
  always_comb begin
    w_thNext   = r_th;
    w_tlNext   = r_tl;
    w_tconNext = r_tcon;

    if (i_wrTh) begin
      w_thNext = i_wdata;
    end

    if (i_wrTl) begin
      w_tlNext = i_wdata;
    end else if (r_tcon[TCON_EN]) begin
      w_tlNext = w_wrap ? r_th : (r_tl + 32'd1);
    end

    if (i_wrTcon) begin
      w_tconNext[TCON_EN] = i_wdata[TCON_EN];
      w_tconNext[TCON_IE] = i_wdata[TCON_IE];
      w_tconNext[TCON_IS] = r_tcon[TCON_IS] & i_wdata[TCON_IS];
    end

    if (w_setIs) begin
      w_tconNext[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      r_th   <= w_thNext;
      r_tl   <= w_tlNext;
      r_tcon <= w_tconNext;
    end
  end

  assign o_th   = r_th;
  assign o_tl   = r_tl;
  assign o_tcon = r_tcon;
  assign o_irq  = r_tcon[TCON_IS];

endmodule

// File: rtl/data_mem_mmio.sv
// data_mem_mmio: MEM-stage data memory. Word-organised RAM with byte/half/word
// little-endian access plus a 256-byte peripheral window (timer, LED, 7-segment,
// optional SYSTICK). Loads are combinational; stores and peripheral state are clocked.
// Optional feature: define DM_SYSTICK_EN to build the free-running cycle counter
// readable at window offset 0x14; otherwise that offset reads 0.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   addr       byte address
//   wdata      store data, right-aligned for byte/half
//   mem_read   load enable;  mem_write  store enable
//   size       00 byte, 01 half, 10/11 word
//   sign_ext   sign-extend byte/half loads
//   rdata      load result (0 when not reading or misaligned)
//   misalign   access violates its natural alignment
//   led_data   LED register, zero-extended
//   digi_data  7-segment register, zero-extended
//   irq        timer interrupt
module data_mem_mmio
  import dm_pkg::*;
#(
  parameter int                RAM_WORDS = 512,
  parameter int                RAM_AW    = 9,
  parameter logic [31:0]       MMIO_BASE = 32'h4000_0000,
  parameter int                LED_W     = 8,
  parameter int                DIGI_W    = 12,
  parameter logic [LED_W-1:0]  LED_RST   = 8'hAB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [31:0] led_data,
  output logic [31:0] digi_data,
  output logic        irq
);

  logic [31:0]       r_ram [RAM_WORDS];
  logic [LED_W-1:0]  r_led;
  logic [DIGI_W-1:0] r_digi;

  logic              w_isMmio;
  logic              w_misalign;
  logic              w_ramWe;
  logic              w_mmioWe;
  logic [RAM_AW-1:0] w_ramIdx;
  logic [7:0]        w_mmioOff;
  logic [3:0]        w_byteEn;
  logic [31:0]       w_wLane;
  logic [31:0]       w_ramWord;
  logic [31:0]       w_ramLoad;
  logic [31:0]       w_mmioLoad;
  logic [31:0]       w_sysTick;
  logic [31:0]       w_th;
  logic [31:0]       w_tl;
  logic [2:0]        w_tcon;

  assign w_isMmio   = (addr[31:8] == MMIO_BASE[31:8]);
  assign w_misalign = isMisaligned(size, addr[1:0]);
  assign w_ramIdx   = addr[RAM_AW+1:2];
  // Peripherals are full-word registers, so the byte lane bits are ignored in decode.
  assign w_mmioOff  = {addr[7:2], 2'b00};
  assign w_ramWe    = mem_write && !w_misalign && !w_isMmio;
  assign w_mmioWe   = mem_write && !w_misalign && w_isMmio;

  // Store data is replicated across lanes so each enabled lane picks its own byte.
  always_comb begin
    w_byteEn = 4'b1111;
    w_wLane  = wdata;
    case (size)
      SZ_BYTE: begin
        w_byteEn = 4'b0001 << addr[1:0];
        w_wLane  = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        w_byteEn = addr[1] ? 4'b1100 : 4'b0011;
        w_wLane  = {2{wdata[15:0]}};
      end
      default: begin
        w_byteEn = 4'b1111;
        w_wLane  = wdata;
      end
    endcase
  end

  // No reset on the array so it maps onto block RAM with byte write enables.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_ramWe && w_byteEn[i]) begin
        r_ram[w_ramIdx][8*i +: 8] <= w_wLane[8*i +: 8];
      end
    end
  end

  assign w_ramWord = r_ram[w_ramIdx];

  always_comb begin
    w_ramLoad = w_ramWord;
    case (size)
      SZ_BYTE: begin
        case (addr[1:0])
          2'd0:    w_ramLoad = {{24{sign_ext & w_ramWord[7]}},  w_ramWord[7:0]};
          2'd1:    w_ramLoad = {{24{sign_ext & w_ramWord[15]}}, w_ramWord[15:8]};
          2'd2:    w_ramLoad = {{24{sign_ext & w_ramWord[23]}}, w_ramWord[23:16]};
          default: w_ramLoad = {{24{sign_ext & w_ramWord[31]}}, w_ramWord[31:24]};
        endcase
      end
      SZ_HALF: begin
        if (addr[1]) begin
          w_ramLoad = {{16{sign_ext & w_ramWord[31]}}, w_ramWord[31:16]};
        end else begin
          w_ramLoad = {{16{sign_ext & w_ramWord[15]}}, w_ramWord[15:0]};
        end
      end
      default: w_ramLoad = w_ramWord;
    endcase
  end

  dm_timer u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .i_wrTh   (w_mmioWe && (w_mmioOff == OFF_TH)),
    .i_wrTl   (w_mmioWe && (w_mmioOff == OFF_TL)),
    .i_wrTcon (w_mmioWe && (w_mmioOff == OFF_TCON)),
    .i_wdata  (wdata),
    .o_th     (w_th),
    .o_tl     (w_tl),
    .o_tcon   (w_tcon),
    .o_irq    (irq)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led  <= LED_RST;
      r_digi <= '0;
    end else if (w_mmioWe) begin
      if (w_mmioOff == OFF_LED) begin
        r_led <= wdata[LED_W-1:0];
      end
      if (w_mmioOff == OFF_DIGI) begin
        r_digi <= wdata[DIGI_W-1:0];
      end
    end
  end

`ifdef DM_SYSTICK_EN
  logic [31:0] r_sysTick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sysTick <= '0;
    end else begin
      r_sysTick <= r_sysTick + 32'd1;
    end
  end

  assign w_sysTick = r_sysTick;
`else
  assign w_sysTick = '0;
`endif

  always_comb begin
    w_mmioLoad = '0;
    case (w_mmioOff)
      OFF_TH:      w_mmioLoad = w_th;
      OFF_TL:      w_mmioLoad = w_tl;
      OFF_TCON:    w_mmioLoad = {29'd0, w_tcon};
      OFF_LED:     w_mmioLoad = 32'(r_led);
      OFF_DIGI:    w_mmioLoad = 32'(r_digi);
      OFF_SYSTICK: w_mmioLoad = w_sysTick;
      default:     w_mmioLoad = '0;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (mem_read && !w_misalign) begin
      rdata = w_isMmio ? w_mmioLoad : w_ramLoad;
    end
  end

  assign misalign  = w_misalign;
  assign led_data  = 32'(r_led);
  assign digi_data = 32'(r_digi);

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: directed and randomized stimulus for data_mem_mmio, checked
// against a byte-array / register-level reference model held in the bench.
module tb_data_mem_mmio;

  localparam int          NWORDS = 512;
  localparam logic [31:0] BASE   = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        misalign;
  logic [31:0] led_data;
  logic [31:0] digi_data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  mMem [NWORDS*4];
  logic [31:0] mTh, mTl, mSys;
  logic        mEn, mIe, mIs;
  logic [7:0]  mLed;
  logic [11:0] mDigi;

  data_mem_mmio dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .size      (size),
    .sign_ext  (sign_ext),
    .rdata     (rdata),
    .misalign  (misalign),
    .led_data  (led_data),
    .digi_data (digi_data),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  function automatic logic modelMis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b01) return a[0];
    if (sz[1])       return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic isMmioAddr(input logic [31:0] a);
    return a[31:8] == BASE[31:8];
  endfunction

  function automatic int byteBase(input logic [31:0] a);
    return int'((a >> 2) % NWORDS) * 4;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz,
                                            input logic se);
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    int          bb;
    if (modelMis(a, sz)) return 32'd0;
    if (isMmioAddr(a)) begin
      case (a[7:2])
        6'd0: return mTh;
        6'd1: return mTl;
        6'd2: return {29'd0, mIs, mIe, mEn};
        6'd3: return {24'd0, mLed};
        6'd4: return {20'd0, mDigi};
`ifdef DM_SYSTICK_EN
        6'd5: return mSys;
`endif
        default: return 32'd0;
      endcase
    end
    bb   = byteBase(a);
    word = {mMem[bb+3], mMem[bb+2], mMem[bb+1], mMem[bb]};
    if (sz == 2'b00) begin
      b = mMem[bb + int'(a[1:0])];
      return se ? {{24{b[7]}}, b} : {24'd0, b};
    end
    if (sz == 2'b01) begin
      h = a[1] ? word[31:16] : word[15:0];
      return se ? {{16{h[15]}}, h} : {16'd0, h};
    end
    return word;
  endfunction

  task automatic modelReset();
    mTh = 0; mTl = 0; mSys = 0;
    mEn = 0; mIe = 0; mIs = 0;
    mLed = 8'hAB; mDigi = 0;
  endtask

  // Advances the model by one clock edge, using the state seen before the edge.
  task automatic modelCommit(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz);
    logic        doWr, wTh, wTl, wTc, overflow;
    logic [31:0] nTl;
    int          bb;
    doWr = wr && !modelMis(a, sz);
    wTh = 0; wTl = 0; wTc = 0;
    if (doWr && isMmioAddr(a)) begin
      case (a[7:2])
        6'd0: wTh = 1;
        6'd1: wTl = 1;
        6'd2: wTc = 1;
        6'd3: mLed = d[7:0];
        6'd4: mDigi = d[11:0];
        default: ;
      endcase
    end
    overflow = mEn && (mTl == 32'hFFFF_FFFF);
    if (wTl)           nTl = d;
    else if (!mEn)     nTl = mTl;
    else if (overflow) nTl = mTh;
    else               nTl = mTl + 1;
    mIs = (wTc ? (mIs && d[2]) : mIs) || (overflow && mIe);
    if (wTc) begin
      mEn = d[0];
      mIe = d[1];
    end
    if (wTh) mTh = d;
    mTl  = nTl;
    mSys = mSys + 1;
    if (doWr && !isMmioAddr(a)) begin
      bb = byteBase(a);
      case (sz)
        2'b00: mMem[bb + int'(a[1:0])] = d[7:0];
        2'b01: begin
          mMem[bb + (a[1] ? 2 : 0)]     = d[7:0];
          mMem[bb + (a[1] ? 2 : 0) + 1] = d[15:8];
        end
        default: for (int i = 0; i < 4; i++) mMem[bb+i] = d[8*i +: 8];
      endcase
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One full clock: drive at the falling edge, check combinational outputs,
  // take the rising edge, then check the registered outputs.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] sz, input logic se);
    mem_read = rd; mem_write = wr; addr = a; wdata = d; size = sz; sign_ext = se;
    #1;
    checkOutput("rdata", rdata, rd ? modelLoad(a, sz, se) : 32'd0);
    checkOutput("misalign", {31'd0, misalign}, {31'd0, modelMis(a, sz)});
    @(posedge clk);
    modelCommit(wr, a, d, sz);
    @(negedge clk);
    mem_read = 0; mem_write = 0;
    #1;
    checkOutput("irq", {31'd0, irq}, {31'd0, mIs});
    checkOutput("led", led_data, {24'd0, mLed});
    checkOutput("digi", digi_data, {20'd0, mDigi});
  endtask

  // Combinational load with no clock edge; compares against a given expectation.
  task automatic probe(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic se, input logic [31:0] expected);
    mem_read = 1; mem_write = 0; addr = a; size = sz; sign_ext = se;
    #1;
    checkOutput(tag, rdata, expected);
    mem_read = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'd0, 32'd0, 2'b10, 0);
  endtask

  initial begin
    reset = 0; addr = 0; wdata = 0; mem_read = 0; mem_write = 0; size = 0; sign_ext = 0;
    modelReset();
    repeat (3) @(negedge clk);
    reset = 1;
    #1;
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_led", led_data, 32'h0000_00AB);
    checkOutput("rst_digi", digi_data, 32'd0);
    probe("rst_tcon", BASE + 32'h8, 2'b10, 0, 32'd0);
    probe("rst_tl", BASE + 32'h4, 2'b10, 0, 32'd0);

    // Fill the RAM so every later load has a known model value
    for (int i = 0; i < NWORDS; i++) applyStimulus(0, 1, i * 4, $urandom, 2'b10, 0);

    // Byte lanes and extension
    applyStimulus(0, 1, 32'h10, 32'h1122_3344, 2'b10, 0);
    applyStimulus(0, 1, 32'h12, 32'h0000_00AA, 2'b00, 0);
    probe("word_after_byte", 32'h10, 2'b10, 0, 32'h11AA_3344);
    probe("byte_signed", 32'h12, 2'b00, 1, 32'hFFFF_FFAA);
    probe("byte_unsigned", 32'h12, 2'b00, 0, 32'h0000_00AA);

    // Misaligned half store is dropped; aligned signed half load
    applyStimulus(0, 1, 32'h20, 32'h8001_7777, 2'b10, 0);
    applyStimulus(1, 1, 32'h21, 32'h0000_BEEF, 2'b01, 0);
    probe("misaligned_unchanged", 32'h20, 2'b10, 0, 32'h8001_7777);
    probe("half_signed", 32'h22, 2'b01, 1, 32'hFFFF_8001);
    probe("misaligned_load", 32'h21, 2'b01, 1, 32'd0);

    // Address wrap
    applyStimulus(0, 1, 32'h800, 32'hCAFE_F00D, 2'b10, 0);
    probe("alias_idx0", 32'h0, 2'b10, 0, 32'hCAFE_F00D);

    // Timer reload and interrupt
    applyStimulus(0, 1, BASE + 32'h0, 32'h10, 2'b10, 0);
    applyStimulus(0, 1, BASE + 32'h4, 32'hFFFF_FFFD, 2'b10, 0);
    applyStimulus(0, 1, BASE + 32'h8, 32'h3, 2'b10, 0);
    idle(2);
    probe("tl_max", BASE + 32'h4, 2'b10, 0, 32'hFFFF_FFFF);
    idle(1);
    probe("tl_reload", BASE + 32'h4, 2'b10, 0, 32'h10);
    checkOutput("irq_set", {31'd0, irq}, 32'd1);
    applyStimulus(0, 1, BASE + 32'h8, 32'h3, 2'b10, 0);
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
    probe("tl_11", BASE + 32'h4, 2'b10, 0, 32'h11);
    idle(1);
    probe("tl_12", BASE + 32'h4, 2'b10, 0, 32'h12);

    // Overflow set beats a clearing write in the same cycle
    applyStimulus(0, 1, BASE + 32'h4, 32'hFFFF_FFFE, 2'b10, 0);
    idle(1);
    applyStimulus(0, 1, BASE + 32'h8, 32'h3, 2'b10, 0);
    checkOutput("irq_race", {31'd0, irq}, 32'd1);
    // CPU write to TL beats the increment
    applyStimulus(0, 1, BASE + 32'h4, 32'h1234_5678, 2'b10, 0);
    probe("tl_write_wins", BASE + 32'h4, 2'b10, 0, 32'h1234_5678);

    // LED/DIGI, then reset mid-count
    applyStimulus(0, 1, BASE + 32'hC, 32'hFFFF_FF5A, 2'b10, 0);
    applyStimulus(0, 1, BASE + 32'h10, 32'hFFFF_F123, 2'b10, 0);
    checkOutput("digi_wr", digi_data, 32'h123);
    reset = 0;
    modelReset();
    #1;
    checkOutput("midrst_irq", {31'd0, irq}, 32'd0);
    checkOutput("midrst_led", led_data, 32'hAB);
    checkOutput("midrst_digi", digi_data, 32'd0);
    probe("midrst_tcon", BASE + 32'h8, 2'b10, 0, 32'd0);
    reset = 1;
    #1;
    probe("ram_retained", 32'h10, 2'b10, 0, 32'h11AA_3344);

    idle(7);
`ifdef DM_SYSTICK_EN
    probe("systick", BASE + 32'h14, 2'b10, 0, 32'd7);
`else
    probe("systick", BASE + 32'h14, 2'b10, 0, 32'd0);
`endif

    // Randomized traffic over RAM and the peripheral window
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) < 2) a = BASE | ($urandom_range(0, 7) << 2) | ($urandom & 3);
      else a = $urandom;
      applyStimulus(1'($urandom), 1'($urandom), a, $urandom, 2'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
